// File: rtl/fdma_pkg.sv
// Shared types and constants for the FDMA read/write arbiter.
// Optional statistics are built when FDMA_ARB_STATS_EN is defined.
package fdma_pkg;

    localparam int FDMA_SIZE_W = 16;
    localparam int STREAK_W    = 8;
    localparam int WAIT_W      = 16;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        BUSY,
        DONE
    } arb_state_t;

    typedef enum logic {
        GNT_W,
        GNT_R
    } grant_t;

    function automatic logic [STREAK_W-1:0] streak_inc(
        input logic [STREAK_W-1:0] v
    );
        return (&v) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/fdma_arb_stats.sv
// Grant counters and worst-case write wait for the FDMA arbiter.
// Instantiated only when FDMA_ARB_STATS_EN is defined.
module fdma_arb_stats
    import fdma_pkg::*;
(
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_wr_gnt,
    input  logic              i_rd_gnt,
    input  logic              i_wr_pend,
    output logic [31:0]       o_wr_grants,
    output logic [31:0]       o_rd_grants,
    output logic [WAIT_W-1:0] o_wr_max_wait
);

    logic [31:0]       r_wr_grants;
    logic [31:0]       r_rd_grants;
    logic [WAIT_W-1:0] r_wait;
    logic [WAIT_W-1:0] r_max;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr_grants <= '0;
            r_rd_grants <= '0;
            r_wait      <= '0;
            r_max       <= '0;
        end else begin
            if (i_wr_gnt)
                r_wr_grants <= r_wr_grants + 32'd1;
            if (i_rd_gnt)
                r_rd_grants <= r_rd_grants + 32'd1;
            // Wait counts cycles a write request has been held without a grant
            if (i_wr_gnt) begin
                r_wait <= '0;
                if (r_wait > r_max)
                    r_max <= r_wait;
            end else if (i_wr_pend) begin
                if (!(&r_wait))
                    r_wait <= r_wait + 1'b1;
            end else begin
                r_wait <= '0;
            end
        end
    end

    assign o_wr_grants   = r_wr_grants;
    assign o_rd_grants   = r_rd_grants;
    assign o_wr_max_wait = r_max;

endmodule

// File: rtl/fdma_rw_arbiter.sv
// Burst-level arbiter sharing one FDMA engine between a write and a read master.
// Define FDMA_ARB_STATS_EN to add grant/wait statistics outputs.
module fdma_rw_arbiter
    import fdma_pkg::*;
#(
    parameter int AXI_DATA_WIDTH = 32,
    parameter int AXI_ADDR_WIDTH = 23,
    parameter int MAX_RD_STREAK  = 4
) (
    input  logic                      ui_clk,
    input  logic                      ui_rstn,
    input  logic [AXI_ADDR_WIDTH-1:0] s_waddr,
    input  logic                      s_wareq,
    input  logic [FDMA_SIZE_W-1:0]    s_wsize,
    output logic                      s_wbusy,
    input  logic [AXI_DATA_WIDTH-1:0] s_wdata,
    output logic                      s_wvalid,
    input  logic [AXI_ADDR_WIDTH-1:0] s_raddr,
    input  logic                      s_rareq,
    input  logic [FDMA_SIZE_W-1:0]    s_rsize,
    output logic                      s_rbusy,
    output logic [AXI_DATA_WIDTH-1:0] s_rdata,
    output logic                      s_rvalid,
    output logic [AXI_ADDR_WIDTH-1:0] fdma_addr,
    output logic                      fdma_areq,
    output logic                      fdma_rnw,
    output logic [FDMA_SIZE_W-1:0]    fdma_size,
    input  logic                      fdma_busy,
    output logic [AXI_DATA_WIDTH-1:0] fdma_wdata,
    input  logic                      fdma_wvalid,
    input  logic [AXI_DATA_WIDTH-1:0] fdma_rdata,
    input  logic                      fdma_rvalid
`ifdef FDMA_ARB_STATS_EN
    ,
    output logic [31:0]               stat_wr_grants,
    output logic [31:0]               stat_rd_grants,
    output logic [WAIT_W-1:0]         stat_wr_max_wait
`endif
);

    arb_state_t                r_state;
    grant_t                    r_grant;
    logic                      r_areq;
    logic                      r_rnw;
    logic                      r_wbusy;
    logic                      r_rbusy;
    logic [AXI_ADDR_WIDTH-1:0] r_addr;
    logic [FDMA_SIZE_W-1:0]    r_size;
    logic [STREAK_W-1:0]       r_streak;

    logic w_idle;
    logic w_rd_win;
    logic w_rd_gnt;
    logic w_wr_gnt;
    logic w_wsel;
    logic w_rsel;

    // Reads may only starve a pending write for MAX_RD_STREAK grants
    assign w_idle   = (r_state == IDLE);
    assign w_rd_win = s_rareq &&
                      ((r_streak < STREAK_W'(MAX_RD_STREAK)) || !s_wareq);
    assign w_rd_gnt = w_idle && w_rd_win;
    assign w_wr_gnt = w_idle && s_wareq && !w_rd_win;

    always_ff @(posedge ui_clk or negedge ui_rstn) begin
        if (!ui_rstn) begin
            r_state  <= IDLE;
            r_grant  <= GNT_W;
            r_areq   <= 1'b0;
            r_rnw    <= 1'b0;
            r_wbusy  <= 1'b0;
            r_rbusy  <= 1'b0;
            r_addr   <= '0;
            r_size   <= '0;
            r_streak <= '0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (w_rd_gnt || w_wr_gnt) begin
                        r_state <= REQ;
                        r_areq  <= 1'b1;
                        r_rnw   <= w_rd_gnt;
                        r_grant <= w_rd_gnt ? GNT_R : GNT_W;
                        r_addr  <= w_rd_gnt ? s_raddr : s_waddr;
                        r_size  <= w_rd_gnt ? s_rsize : s_wsize;
                        r_rbusy <= w_rd_gnt;
                        r_wbusy <= w_wr_gnt;
                        if (w_wr_gnt)
                            r_streak <= '0;
                        else if (s_wareq)
                            r_streak <= streak_inc(r_streak);
                    end
                end
                REQ: begin
                    if (fdma_busy) begin
                        r_areq  <= 1'b0;
                        r_state <= BUSY;
                    end
                end
                BUSY: begin
                    if (!fdma_busy) begin
                        r_state <= DONE;
                        r_wbusy <= 1'b0;
                        r_rbusy <= 1'b0;
                    end
                end
                DONE: r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end

    // Beats are only routed while the engine owns the granted burst
    assign w_wsel = (r_state == BUSY) && (r_grant == GNT_W);
    assign w_rsel = (r_state == BUSY) && (r_grant == GNT_R);

    assign fdma_areq  = r_areq && !fdma_busy;
    assign fdma_addr  = r_addr;
    assign fdma_size  = r_size;
    assign fdma_rnw   = r_rnw;
    assign s_wbusy    = r_wbusy;
    assign s_rbusy    = r_rbusy;
    assign fdma_wdata = w_wsel ? s_wdata : '0;
    assign s_wvalid   = w_wsel && fdma_wvalid;
    assign s_rdata    = w_rsel ? fdma_rdata : '0;
    assign s_rvalid   = w_rsel && fdma_rvalid;

`ifdef FDMA_ARB_STATS_EN
    fdma_arb_stats u_stats (
        .i_clk         (ui_clk),
        .i_rst_n       (ui_rstn),
        .i_wr_gnt      (w_wr_gnt),
        .i_rd_gnt      (w_rd_gnt),
        .i_wr_pend     (s_wareq),
        .o_wr_grants   (stat_wr_grants),
        .o_rd_grants   (stat_rd_grants),
        .o_wr_max_wait (stat_wr_max_wait)
    );
`endif

endmodule
